// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the memory-port arbiter.
//   state_t  - sequencing state of the single outstanding transaction
//   OWN_*    - which requester owns the transaction in flight
//   CNT_W    - width of the starvation counter (STARVE_MAX up to 15)
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    RESP      = 2'd3
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick: grant selection between IF and LS plus the IF starvation counter.
// LS normally has priority; once STARVE_MAX consecutive LS grants have been
// given while IF was waiting, IF gets the next grant.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   idle            - arbiter is in IDLE (grants only happen there)
//   if_req_valid    - IF requester wants the port
//   ls_req_valid    - LS requester wants the port
//   if_grant        - IF granted this cycle (already qualified by idle)
//   ls_grant        - LS granted this cycle (already qualified by idle)
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic if_req_valid,
  input  logic ls_req_valid,
  output logic if_grant,
  output logic ls_grant
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic             if_win;
  logic             ls_win;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    if_win   = if_req_valid & (~ls_req_valid | (cnt_q == CNT_MAX));
    ls_win   = ls_req_valid & ~if_win;
    if_grant = idle & if_win;
    ls_grant = idle & ls_win;
  end

  // The counter only moves in IDLE; it holds across a transaction so that
  // the next arbitration sees how many LS grants IF has already lost.
  always_comb begin
    cnt_d = cnt_q;
    if (idle) begin
      if (if_win || !if_req_valid) begin
        cnt_d = '0;
      end else if (ls_win && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction-fetch (IF,
// read-only) and load/store (LS) requesters, one transaction at a time,
// sequenced IDLE -> ISSUE -> WAIT_RESP -> RESP.
// Handshake: a request transfers on any cycle where valid and ready are both
// 1; ready never depends on anything but the current state and valids, and
// a requester may change its inputs freely after the transfer.
// Ports:
//   clk, rst                      - clock, asynchronous active-low reset
//   if_req_valid/ready, if_addr   - IF request channel
//   if_resp_valid, if_rdata       - IF response (one-cycle pulse, data held)
//   ls_req_valid/ready, ls_addr,
//   ls_wen, ls_wdata, ls_wmask    - LS request channel
//   ls_resp_valid, ls_rdata       - LS response (rdata 0 for writes)
//   mem_req_valid/ready, mem_addr,
//   mem_wen, mem_wdata, mem_wmask - memory request channel
//   mem_resp_valid, mem_rdata     - memory response
//   err_spurious                  - sticky: response seen outside WAIT_RESP
//   dbg_state                     - current sequencing state
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err_spurious,
  output state_t              dbg_state
);

  state_t state_q;
  state_t state_d;
  logic   owner_q;
  logic   if_grant;
  logic   ls_grant;
  logic   resp_take;

  arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk          (clk),
    .rst          (rst),
    .idle         (state_q == IDLE),
    .if_req_valid (if_req_valid),
    .ls_req_valid (ls_req_valid),
    .if_grant     (if_grant),
    .ls_grant     (ls_grant)
  );

  // Next state and state-derived outputs.
  always_comb begin
    state_d       = state_q;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    if_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if_req_ready = if_grant;
        ls_req_ready = ls_grant;
        if (if_grant || ls_grant) state_d = ISSUE;
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (mem_resp_valid) state_d = RESP;
      end
      RESP: begin
        if_resp_valid = (owner_q == OWN_IF);
        ls_resp_valid = (owner_q == OWN_LS);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_take = (state_q == WAIT_RESP) && mem_resp_valid;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture: mem_* are registered at the grant and held until the
  // next grant, so they stay stable through any ISSUE back-pressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q   <= OWN_IF;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (if_grant) begin
      owner_q   <= OWN_IF;
      mem_addr  <= if_addr;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (ls_grant) begin
      owner_q   <= OWN_LS;
      mem_addr  <= ls_addr;
      mem_wen   <= ls_wen;
      mem_wdata <= ls_wdata;
      mem_wmask <= ls_wmask;
    end
  end

  // Response data is captured on the WAIT_RESP->RESP edge and held until
  // the same requester receives its next response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata <= '0;
      ls_rdata <= '0;
    end else if (resp_take) begin
      if (owner_q == OWN_IF) begin
        if_rdata <= mem_rdata;
      end else begin
        ls_rdata <= mem_wen ? '0 : mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_spurious <= 1'b0;
    end else if (mem_resp_valid && (state_q != WAIT_RESP)) begin
      err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [31:0] if_addr = '0;
  logic        if_resp_valid;
  logic [31:0] if_rdata;
  logic        ls_req_valid = 1'b0;
  logic        ls_req_ready;
  logic [31:0] ls_addr = '0;
  logic        ls_wen = 1'b0;
  logic [31:0] ls_wdata = '0;
  logic [3:0]  ls_wmask = '0;
  logic        ls_resp_valid;
  logic [31:0] ls_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        err_spurious;
  state_t      dbg_state;

  int passed = 0;
  int total  = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .err_spurious(err_spurious), .dbg_state(dbg_state)
  );

  // Watchdog: the bench never waits on a DUT event, but guard anyway.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Entered at the negedge of the ISSUE cycle; leaves at the negedge of the
  // RESP cycle. ready_wait = cycles mem_req_ready stays low; resp_wait = cycles
  // from the handshake to mem_resp_valid (>= 1).
  task automatic mem_serve(input logic [31:0] rdata, input int ready_wait, input int resp_wait);
    for (int i = 0; i < ready_wait; i++) @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int i = 1; i < resp_wait; i++) @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_rdata      = rdata;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'h5A5A_5A5A;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b0;
    #3;
    total++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE); else passed++;
    total++;
    if ({mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, if_resp_valid, ls_resp_valid,
         if_rdata, ls_rdata, err_spurious, if_req_ready, ls_req_ready} !== '0)
      $display("FAIL reset_outputs: got nonzero outputs mem_addr=%h mem_req_valid=%b required all 0", mem_addr, mem_req_valid);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_if_fetch;
    if_req_valid = 1'b1;
    if_addr      = 32'h8000_0000;
    #1;
    total++; if (if_req_ready !== 1'b1) $display("FAIL if_ready: got %b required 1", if_req_ready); else passed++;
    total++; if (ls_req_ready !== 1'b0) $display("FAIL if_ls_ready: got %b required 0", ls_req_ready); else passed++;
    @(negedge clk);
    if_req_valid = 1'b0;
    if_addr      = 32'h1111_2222;
    total++; if (mem_req_valid !== 1'b1) $display("FAIL if_mem_valid: got %b required 1", mem_req_valid); else passed++;
    total++; if (mem_addr !== 32'h8000_0000) $display("FAIL if_mem_addr: got %h required 80000000", mem_addr); else passed++;
    total++; if (mem_wen !== 1'b0) $display("FAIL if_mem_wen: got %b required 0", mem_wen); else passed++;
    mem_serve(32'h0010_0073, 0, 2);
    total++; if (if_resp_valid !== 1'b1) $display("FAIL if_resp_pulse: got %b required 1", if_resp_valid); else passed++;
    total++; if (if_rdata !== 32'h0010_0073) $display("FAIL if_rdata: got %h required 00100073", if_rdata); else passed++;
    total++; if (ls_resp_valid !== 1'b0) $display("FAIL if_ls_resp: got %b required 0", ls_resp_valid); else passed++;
    @(negedge clk);
    total++; if (if_resp_valid !== 1'b0) $display("FAIL if_resp_single: got %b required 0", if_resp_valid); else passed++;
    total++; if (if_rdata !== 32'h0010_0073) $display("FAIL if_rdata_hold: got %h required 00100073", if_rdata); else passed++;
    total++; if (dbg_state !== IDLE) $display("FAIL if_back_idle: got %0d required %0d", dbg_state, IDLE); else passed++;
  endtask

  task automatic test_simultaneous;
    if_req_valid = 1'b1;
    if_addr      = 32'h8000_0100;
    ls_req_valid = 1'b1;
    ls_addr      = 32'h8000_1000;
    ls_wen       = 1'b0;
    #1;
    total++; if (ls_req_ready !== 1'b1) $display("FAIL sim_ls_ready: got %b required 1", ls_req_ready); else passed++;
    total++; if (if_req_ready !== 1'b0) $display("FAIL sim_if_ready: got %b required 0", if_req_ready); else passed++;
    @(negedge clk);
    ls_req_valid = 1'b0;
    total++; if (mem_addr !== 32'h8000_1000) $display("FAIL sim_mem_addr: got %h required 80001000", mem_addr); else passed++;
    total++; if (if_req_ready !== 1'b0) $display("FAIL sim_if_ready_busy: got %b required 0", if_req_ready); else passed++;
    mem_serve(32'h1234_5678, 0, 1);
    total++; if (ls_resp_valid !== 1'b1) $display("FAIL sim_ls_resp: got %b required 1", ls_resp_valid); else passed++;
    total++; if (ls_rdata !== 32'h1234_5678) $display("FAIL sim_ls_rdata: got %h required 12345678", ls_rdata); else passed++;
    total++; if (if_req_ready !== 1'b0) $display("FAIL sim_if_ready_resp: got %b required 0", if_req_ready); else passed++;
    @(negedge clk);
    total++; if (if_req_ready !== 1'b1) $display("FAIL sim_if_grant_next: got %b required 1", if_req_ready); else passed++;
    @(negedge clk);
    if_req_valid = 1'b0;
    total++; if (mem_addr !== 32'h8000_0100) $display("FAIL sim_if_mem_addr: got %h required 80000100", mem_addr); else passed++;
    mem_serve(32'hCAFE_0001, 0, 1);
    total++; if (if_rdata !== 32'hCAFE_0001) $display("FAIL sim_if_rdata: got %h required cafe0001", if_rdata); else passed++;
    @(negedge clk);
  endtask

  task automatic test_starvation;
    logic exp_if;
    if_req_valid = 1'b1;
    if_addr      = 32'h8000_0200;
    ls_req_valid = 1'b1;
    ls_addr      = 32'h8000_3000;
    ls_wen       = 1'b0;
    // Expected grant order with STARVE_MAX=4: LS x4, IF, then LS again.
    for (int g = 0; g < 6; g++) begin
      exp_if = (g == 4);
      #1;
      total++;
      if (if_req_ready !== exp_if || ls_req_ready !== !exp_if)
        $display("FAIL starve_grant%0d: got if=%b ls=%b required if=%b ls=%b", g, if_req_ready, ls_req_ready, exp_if, !exp_if);
      else passed++;
      @(negedge clk);
      total++;
      if (mem_addr !== (exp_if ? 32'h8000_0200 : 32'h8000_3000))
        $display("FAIL starve_addr%0d: got %h required %h", g, mem_addr, exp_if ? 32'h8000_0200 : 32'h8000_3000);
      else passed++;
      mem_serve(32'h0000_0100 + g, 0, 1);
      total++;
      if (if_resp_valid !== exp_if || ls_resp_valid !== !exp_if)
        $display("FAIL starve_resp%0d: got if=%b ls=%b required if=%b ls=%b", g, if_resp_valid, ls_resp_valid, exp_if, !exp_if);
      else passed++;
      @(negedge clk);
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write;
    ls_req_valid = 1'b1;
    ls_addr      = 32'h8000_2004;
    ls_wen       = 1'b1;
    ls_wdata     = 32'hDEAD_BEEF;
    ls_wmask     = 4'b0011;
    #1;
    total++; if (ls_req_ready !== 1'b1) $display("FAIL wr_ready: got %b required 1", ls_req_ready); else passed++;
    @(negedge clk);
    ls_req_valid = 1'b0;
    ls_wen       = 1'b0;
    ls_wdata     = '0;
    ls_wmask     = '0;
    total++;
    if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== {32'h8000_2004, 1'b1, 32'hDEAD_BEEF, 4'b0011})
      $display("FAIL wr_mem_fields: got addr=%h wen=%b wdata=%h wmask=%b required 80002004 1 deadbeef 0011",
               mem_addr, mem_wen, mem_wdata, mem_wmask);
    else passed++;
    mem_serve(32'hFFFF_FFFF, 0, 1);
    total++; if (ls_resp_valid !== 1'b1) $display("FAIL wr_resp: got %b required 1", ls_resp_valid); else passed++;
    total++; if (ls_rdata !== 32'h0) $display("FAIL wr_rdata_zero: got %h required 00000000", ls_rdata); else passed++;
    @(negedge clk);
  endtask

  task automatic test_stall;
    if_req_valid = 1'b1;
    if_addr      = 32'h8000_4000;
    @(negedge clk);
    // Keep both requesters asking so the ready checks are meaningful.
    ls_req_valid = 1'b1;
    if_addr      = 32'h0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_4000 || if_req_ready !== 1'b0 || ls_req_ready !== 1'b0)
        $display("FAIL stall_c%0d: got valid=%b addr=%h if_rdy=%b ls_rdy=%b required 1 80004000 0 0",
                 c, mem_req_valid, mem_addr, if_req_ready, ls_req_ready);
      else passed++;
      @(negedge clk);
    end
    if_req_valid  = 1'b0;
    ls_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    total++; if (dbg_state !== WAIT_RESP) $display("FAIL stall_handshake: got %0d required %0d", dbg_state, WAIT_RESP); else passed++;
    total++; if (mem_req_valid !== 1'b0) $display("FAIL stall_wait_valid: got %b required 0", mem_req_valid); else passed++;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0BAD_F00D;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    total++; if (if_resp_valid !== 1'b1 || if_rdata !== 32'h0BAD_F00D) $display("FAIL stall_resp: got %b %h required 1 0badf00d", if_resp_valid, if_rdata); else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    ls_req_valid = 1'b1;
    ls_addr      = 32'h8000_5000;
    ls_wen       = 1'b0;
    @(negedge clk);
    ls_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    total++; if (dbg_state !== WAIT_RESP) $display("FAIL rm_in_wait: got %0d required %0d", dbg_state, WAIT_RESP); else passed++;
    rst = 1'b0;
    #1;
    total++; if (dbg_state !== IDLE) $display("FAIL rm_state: got %0d required %0d", dbg_state, IDLE); else passed++;
    total++; if (mem_addr !== 32'h0) $display("FAIL rm_mem_addr: got %h required 00000000", mem_addr); else passed++;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (ls_resp_valid !== 1'b0 || if_resp_valid !== 1'b0)
        $display("FAIL rm_no_resp%0d: got ls=%b if=%b required 0 0", c, ls_resp_valid, if_resp_valid);
      else passed++;
    end
    total++; if (err_spurious !== 1'b0) $display("FAIL spur_before: got %b required 0", err_spurious); else passed++;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h7777_7777;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    total++; if (err_spurious !== 1'b1) $display("FAIL spur_set: got %b required 1", err_spurious); else passed++;
    total++; if (dbg_state !== IDLE) $display("FAIL spur_ignored: got %0d required %0d", dbg_state, IDLE); else passed++;
    total++; if (ls_rdata !== 32'h0) $display("FAIL spur_no_data: got %h required 00000000", ls_rdata); else passed++;
    repeat (3) @(negedge clk);
    total++; if (err_spurious !== 1'b1) $display("FAIL spur_sticky: got %b required 1", err_spurious); else passed++;
    rst = 1'b0;
    #1;
    total++; if (err_spurious !== 1'b0) $display("FAIL spur_cleared: got %b required 0", err_spurious); else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_if_fetch();
    test_simultaneous();
    test_starvation();
    test_write();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
